// File: rtl/dadda_dot8_acc.sv
// Dot-product engine: registers 8-bit operand pairs, multiplies them with a
// Dadda-style compressed multiplier and accumulates VEC_LEN products per result.

module dadda_8x8_compressed (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 3:2 compressor across a whole row; returns {carry<<1, sum}. Carries out of
  // bit 15 are dropped, which is safe because the product always fits in 16 bits.
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] sum_v;
    logic [15:0] maj_v;
    sum_v = x ^ y ^ z;
    maj_v = (x & y) | (x & z) | (y & z);
    return {maj_v[14:0], 1'b0, sum_v};
  endfunction

  logic [15:0] pp_s [8];
  logic [15:0] s1a_s, c1a_s, s1b_s, c1b_s;
  logic [15:0] s2a_s, c2a_s, s2b_s, c2b_s;
  logic [15:0] s3_s, c3_s, s4_s, c4_s;

  // Partial-product matrix, one shifted row per multiplier bit
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp_s[i] = {8'h00, a & {8{b[i]}}} << i;
    end
  end

  // Height reduction 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
  assign {c1a_s, s1a_s} = csa(pp_s[0], pp_s[1], pp_s[2]);
  assign {c1b_s, s1b_s} = csa(pp_s[3], pp_s[4], pp_s[5]);
  assign {c2a_s, s2a_s} = csa(s1a_s, c1a_s, s1b_s);
  assign {c2b_s, s2b_s} = csa(c1b_s, pp_s[6], pp_s[7]);
  assign {c3_s, s3_s}   = csa(s2a_s, c2a_s, s2b_s);
  assign {c4_s, s4_s}   = csa(s3_s, c3_s, c2b_s);
  assign p = s4_s + c4_s;

endmodule

module dadda_dot8_acc #(
  parameter int ACC_W   = 24,
  parameter int VEC_LEN = 8,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [7:0]       op_a_r;
  logic [7:0]       op_b_r;
  logic             p_vld_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_acc_r;

  logic [15:0]      prod_s;
  logic [ACC_W:0]   sum_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             last_s;
  logic             deliver_s;

  dadda_8x8_compressed u_mul (
    .a (op_a_r),
    .b (op_b_r),
    .p (prod_s)
  );

  // Handshake qualifiers; in_ready depends only on state and clr
  always_comb begin
    in_ready_s = 1'b0;
    if (state_r == ACCUM) begin
      in_ready_s = ~clr;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s  = in_valid & in_ready_s;
  assign last_s    = (cnt_r == CNT_W'(VEC_LEN - 1));
  assign deliver_s = (state_r == HOLD) & out_ready & ~clr;
  assign sum_s     = {1'b0, acc_r} + {{(ACC_W - 15){1'b0}}, prod_s};

  // Next-state logic; clr aborts from any state
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ACCUM;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s && last_s) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        DRAIN: state_nxt_s = HOLD;
        HOLD: begin
          if (out_ready) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: state_nxt_s = ACCUM;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and element counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r  <= 8'h00;
      op_b_r  <= 8'h00;
      p_vld_r <= 1'b0;
      cnt_r   <= '0;
    end else if (clr) begin
      p_vld_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      p_vld_r <= accept_s;
      if (deliver_s) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        op_a_r <= a;
        op_b_r <= b;
        cnt_r  <= cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
      end
    end
  end

  // Accumulator with sticky carry-out flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (clr || deliver_s) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (p_vld_r) begin
      acc_r <= sum_s[ACC_W-1:0];
      ovf_r <= ovf_r | sum_s[ACC_W];
    end
  end

  // Result port; out_acc keeps the last presented result until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_acc_r   <= '0;
    end else if (clr || deliver_s) begin
      out_valid_r <= 1'b0;
    end else if (state_r == DRAIN) begin
      out_valid_r <= 1'b1;
      out_acc_r   <= sum_s[ACC_W-1:0];
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_acc   = out_acc_r;
  assign out_ovf   = ovf_r;

endmodule

// File: doc/dadda_dot8_acc.md
Name: dadda_dot8_acc

Overview:
- Sequential dot-product engine that sits directly downstream of the 8x8 compressed Dadda multiplier.
- Accepts a stream of 8-bit operand pairs over a valid/ready handshake and registers them.
- Feeds the registered pair to an internal dadda_8x8_compressed instance and accumulates the 16-bit products.
- After PARAM VEC_LEN products, presents the sum on a valid/ready output port.

Parameters:
- ACC_W, 24, accumulator/result width in bits; must be >= 16.
- VEC_LEN, 8, number of products per dot product; range 1..256.
- CNT_W, 9, element counter width; must satisfy 2^CNT_W > VEC_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort; discards the partial dot product.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair.
- a  input  8  unsigned multiplicand.
- b  input  8  unsigned multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  dot-product result.
- out_ovf  output  1  sticky flag: carry out of ACC_W occurred during this dot product.

Behaviour:
- Reset: one clock, asynchronous active-high reset named rst, clock named clk.
  - Asserting rst at any time, including mid-vector, forces: state=ACCUM, acc=0, cnt=0, op_a=op_b=0, p_vld=0, out_valid=0, out_ovf=0, out_acc=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Accept: a transfer occurs on a rising edge where in_valid & in_ready. Op registers load a and b, p_vld is set, and cnt increments. No transfer means p_vld clears.
- Product: p = op_a*op_b, taken combinationally from the dadda_8x8_compressed instance; unsigned, 16 bits.
- Accumulate: on each edge with p_vld=1, {carry,acc} <= acc + zero-extended p. out_ovf |= carry. Results wrap modulo 2^ACC_W.
- State machine (3 states):
  - ACCUM: in_ready = ~clr. On the accept that makes cnt==VEC_LEN, go to DRAIN.
  - DRAIN: in_ready=0. The last product is added on this edge; go to HOLD.
  - HOLD: in_ready=0, out_valid=1, out_acc=acc. All outputs are stable while out_ready=0. When out_valid & out_ready: acc=0, cnt=0, out_ovf=0, out_valid=0, go to ACCUM. in_ready=1 on the next cycle.
- Latency:
  - Last pair accepted at edge E0, added to acc at E1, out_valid=1 after E1.
  - Throughput is one pair per cycle within a vector.
  - Minimum gap between vectors is 3 cycles (DRAIN, HOLD, and the handshake cycle).
- out_acc holds the last presented result outside HOLD. It is 0 after reset.
- clr (any state, sync):
  - Next edge: acc=0, cnt=0, p_vld=0, out_ovf=0, out_valid=0, state=ACCUM.
  - in_ready is 0 during a clr cycle, so no pair is consumed.
  - clr in HOLD with out_ready=1 at the same time: clr wins and the result is not counted as delivered.
- VEC_LEN=1: ACCUM to DRAIN on the first accept.
- Zero operands are legal; they count as elements and add 0.
- in_valid while in_ready=0: the pair is not consumed; the source must hold it.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Default params. Stream 8 pairs with no gaps: FF*FF, 10*98, 45*FE, 38*0A, 3B*86, 4C*77, 1D*93, E2*00.
  -> out_valid rises 2 edges after the 8th accept. out_acc=0x01A104, out_ovf=0. in_ready=0 from the edge after the 8th accept until the handshake.
- Same vector with in_valid toggling every other cycle and out_ready held low 5 cycles.
  -> out_acc=0x01A104 stable throughout HOLD. in_ready returns 1 the cycle after out_ready.
- ACC_W=16, VEC_LEN=2. Pairs FF*FF, FF*FF.
  -> out_acc=0xFC02, out_ovf=1. The next vector CF*01 twice gives 0x019E with out_ovf=0.
- Default params. Accept 3 pairs (FF*FF each), then pulse clr with in_valid=1 and a=01, b=01.
  -> that pair is not consumed. Then send 8 pairs of 02*03 -> out_acc=0x000030.
- Assert rst asynchronously between clock edges during DRAIN.
  -> out_valid, out_acc, and out_ovf are 0 immediately. After release, a fresh vector of 8 × 01*01 gives 0x000008.
- VEC_LEN=1. Pairs 45*FE, then 38*0A, with out_ready=1.
  -> two results, 0x004476 then 0x000230, each 2 edges after its accept.
